// File: rtl/serial_to_parallel_if.sv
// Serial receive link bundle: bit stream in, completed word + status out.
// Latency: n/a (wiring only).
// Backpressure: VALID/ACK on DOUT; the serial side has none (EN only paces bits).
interface serial_to_parallel_if #(
  parameter int N = 8
);
  logic         EN;
  logic         SIN;
  logic         SYNC;
  logic         ACK;
  logic [N-1:0] DOUT;
  logic         VALID;
  logic         BUSY;
  logic         OVERRUN;
  logic         PERR;

  // Producer of the serial stream and consumer of the words
  modport master (
    output EN, SIN, SYNC, ACK,
    input  DOUT, VALID, BUSY, OVERRUN, PERR
  );

  // The receiver itself
  modport slave (
    input  EN, SIN, SYNC, ACK,
    output DOUT, VALID, BUSY, OVERRUN, PERR
  );
endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with SYNC word alignment and sticky overrun.
// Latency: word visible on DOUT/VALID right after the edge sampling its last bit.
// Backpressure: none on the stream; a word finishing while VALID=1 and ACK=0 is dropped (OVERRUN).
// Optional: define PARITY_CHECK_EN to expect an even-parity bit after each word (drives PERR).
module serial_to_parallel #(
  parameter int N = 8
) (
  input  logic                  CLK,
  input  logic                  N_RESET,
  serial_to_parallel_if.slave   bus
);

`ifdef PARITY_CHECK_EN
  // Whole word must be held while the parity bit is awaited.
  localparam int SR_W = N;
`else
  // Nth bit goes straight into DOUT, so only N-1 bits need storing.
  localparam int SR_W = N - 1;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    dout_q, dout_d, word;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            perr_q, perr_d, word_perr;
  logic            complete;

  // State register and all datapath flops
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state: SYNC starts/restarts a word, the last bit returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.EN && bus.SYNC) state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.EN && !bus.SYNC && cnt_q == CW'(N - 1)) begin
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.EN) state_d = bus.SYNC ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Shifting, word completion and the VALID/ACK/OVERRUN handshake
  always_comb begin
    sr_shift           = sr_q >> 1;
    sr_shift[SR_W-1]   = bus.SIN;
    sr_d               = sr_q;
    cnt_d              = cnt_q;
    complete           = 1'b0;
    word               = '0;
    word_perr          = 1'b0;

    if (bus.EN) begin
      case (state_q)
        IDLE: begin
          if (bus.SYNC) begin
            sr_d  = sr_shift;
            cnt_d = CW'(1);
          end
        end
        SHIFT: begin
          sr_d  = sr_shift;
          cnt_d = bus.SYNC ? CW'(1) : cnt_q + CW'(1);
`ifndef PARITY_CHECK_EN
          if (!bus.SYNC && cnt_q == CW'(N - 1)) begin
            complete = 1'b1;
            word     = {bus.SIN, sr_q};
          end
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (bus.SYNC) begin
            sr_d  = sr_shift;
            cnt_d = CW'(1);
          end else begin
            complete  = 1'b1;
            word      = sr_q;
            word_perr = (^sr_q) ^ bus.SIN;
          end
        end
`endif
        default: ;
      endcase
    end

    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;
    if (complete) begin
      if (!valid_q || bus.ACK) begin
        dout_d    = word;
        perr_d    = word_perr;
        valid_d   = 1'b1;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.ACK && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign bus.DOUT    = dout_q;
  assign bus.VALID   = valid_q;
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.OVERRUN = overrun_q;
  assign bus.PERR    = perr_q;

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Serial-in, parallel-out receiver. It accepts an LSB-first bit stream, which is the format produced by the team's parallel-to-serial shifter, and assembles N-bit words. Word start is marked by a SYNC strobe. A completed word is presented on DOUT with a VALID/ACK handshake and overrun detection. The block sits at the receiving end of the serial link, feeding parallel logic.

Parameters:
N, 8, data word width in bits (N >= 2)

Ports:
CLK  input  1  clock; all sampling on rising edge
N_RESET  input  1  reset, asynchronous, active-low
EN  input  1  bit-enable; SIN/SYNC sampled only when EN=1
SIN  input  1  serial data in, LSB first
SYNC  input  1  marks that the SIN bit sampled this cycle is bit 0 of a new word
ACK  input  1  consumer accepts DOUT; meaningful only while VALID=1
DOUT  output  N  last completed word
VALID  output  1  DOUT holds an unacknowledged word
BUSY  output  1  word reception in progress
OVERRUN  output  1  sticky: a completed word was lost
PERR  output  1  parity error on current DOUT (optional feature)

Behaviour:
- Reset (N_RESET=0, async): state IDLE; shift reg, bit counter, DOUT = 0; VALID, BUSY, OVERRUN, PERR = 0. Reset mid-word discards the partial word.
- Internal: shift reg sr[N-1:0]; bit counter cnt, width $clog2(N+1); FSM states IDLE, SHIFT (PARITY with feature).
- EN=0: sr, cnt and FSM hold. ACK is still honoured.
- IDLE: SIN is ignored unless EN=1 and SYNC=1. Then sr <= {SIN, sr[N-1:1]}, cnt <= 1, go to SHIFT.
- SHIFT, EN=1, SYNC=0:
  - sr <= {SIN, sr[N-1:1]}, cnt <= cnt+1.
  - When the sampled bit is the Nth (cnt == N-1), the word completes on that edge. Go to IDLE.
- SHIFT, EN=1, SYNC=1: the partial word is aborted. Restart with this bit as bit 0 (cnt <= 1). No flag is raised.
- A word completes in the same cycle a new SYNC arrives only via IDLE. Back-to-back words therefore need SYNC on the first bit of each word.
- BUSY = 1 exactly while in SHIFT (and PARITY).
- Word completion, on the same edge that samples the last bit. DOUT/VALID are visible the next cycle; latency is 0 cycles after the final sampling edge.
  - If VALID=0, or VALID=1 with ACK=1: DOUT <= {SIN, sr[N-1:1]}, VALID <= 1.
  - If VALID=1 with ACK=0: the new word is discarded, DOUT is unchanged, OVERRUN <= 1.
- ACK=1 with VALID=1 and no completion that edge: VALID <= 0, OVERRUN <= 0. ACK while VALID=0 is ignored.
- ACK and completion on the same edge: the new word is loaded, VALID stays 1, OVERRUN is cleared.
- DOUT changes only on completion; it is stable while VALID=1.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - After the Nth data bit the FSM enters PARITY instead of IDLE, and completion is deferred to the PARITY bit.
  - The next EN=1 sample is an even-parity bit. Completion happens on that edge, using the same rules as above.
  - PERR <= (^word) ^ SIN, loaded alongside DOUT and held with it.
  - SYNC=1 in PARITY aborts the word and restarts, as in SHIFT.
- Not defined: no PARITY state; PERR is tied to 0.

Test Plan:
- N=8, EN=1, SYNC on first bit, SIN=1,0,1,0,0,1,0,1 over 8 edges -> after 8th edge DOUT=0xA5, VALID=1, BUSY=0, OVERRUN=0; ACK one cycle -> VALID=0.
- Same 0xA5 stream with EN=0 for 3 cycles after bit 4 -> BUSY stays 1, cnt holds; DOUT=0xA5 after 8 enabled bits.
- Receive 0x3C, no ACK, then receive 0xFF -> DOUT stays 0x3C, VALID=1, OVERRUN=1; ACK -> VALID=0, OVERRUN=0.
- Start word, after 3 bits assert SYNC with stream for 0x81 -> DOUT=0x81 after 8 bits from the second SYNC; no flags.
- Assert N_RESET=0 after 5 bits of a word -> DOUT=0, VALID=0, BUSY=0 immediately; a following SYNC'd 0x5A is received correctly.
- PARITY_CHECK_EN defined: send 0x07 with parity 1 -> PERR=0; send 0x07 with parity 0 -> PERR=1, DOUT=0x07.
